// File: rtl/clockmaster_bus_pkg.sv
// Shared constants and types for the clock-master register bus: block indices,
// arbiter FSM states, default read latency and the block-select decoder.
package clockmaster_bus_pkg;

  localparam logic [3:0] BLK_PPS0     = 4'd0;
  localparam logic [3:0] BLK_PPS1     = 4'd1;
  localparam logic [3:0] BLK_PPS2     = 4'd2;
  localparam logic [3:0] BLK_PPS3     = 4'd3;
  localparam logic [3:0] BLK_PULSE0   = 4'd4;
  localparam logic [3:0] BLK_PULSE1   = 4'd5;
  localparam logic [3:0] BLK_PULSE2   = 4'd6;
  localparam logic [3:0] BLK_PULSE3   = 4'd7;
  localparam logic [3:0] BLK_MEM_BASE = 4'd8;

  localparam int RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic       mem;
    logic [3:0] pulse;
    logic [3:0] pps;
  } blk_sel_t;

  // Block index -> one-hot select; every index from BLK_MEM_BASE up is main memory.
  function automatic blk_sel_t blk_decode(input logic [3:0] blk);
    blk_sel_t sel;
    sel = '0;
    case (blk)
      BLK_PPS0:   sel.pps   = 4'b0001;
      BLK_PPS1:   sel.pps   = 4'b0010;
      BLK_PPS2:   sel.pps   = 4'b0100;
      BLK_PPS3:   sel.pps   = 4'b1000;
      BLK_PULSE0: sel.pulse = 4'b0001;
      BLK_PULSE1: sel.pulse = 4'b0010;
      BLK_PULSE2: sel.pulse = 4'b0100;
      BLK_PULSE3: sel.pulse = 4'b1000;
      default:    sel.mem   = (blk >= BLK_MEM_BASE);
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter. Default: round-robin with a last-served pointer.
// With REG_BUS_ARB_FIXED_PRIO_EN defined, requester 0 always wins and the pointer is gone.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_gnt
);

`ifdef REG_BUS_ARB_FIXED_PRIO_EN
  logic unused_s;
  assign unused_s = ^{i_clk, i_rst, i_update};

  // Fixed priority: requester 0 first.
  always_comb begin
    if (i_req[0]) begin
      o_gnt = 2'b01;
    end else if (i_req[1]) begin
      o_gnt = 2'b10;
    end else begin
      o_gnt = 2'b00;
    end
  end
`else
  // last_q = 1 means requester 1 was served last, so requester 0 is favoured.
  logic last_q;

  // Grant the requester not served last on a tie, otherwise the lone requester.
  always_comb begin
    if (i_req == 2'b11) begin
      o_gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q <= 1'b1;
    end else if (i_update) begin
      last_q <= o_gnt[1];
    end else begin
      last_q <= last_q;
    end
  end
`endif

endmodule

// File: rtl/reg_bus_arbiter.sv
// Register-bus sequencer for the clock-master peripherals: two hosts, one access in flight.
// Arbitration mode selected by macro REG_BUS_ARB_FIXED_PRIO_EN (see rr_arb2).
module reg_bus_arbiter
  import clockmaster_bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic              i_req0_we,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_wdata,
  output logic              o_req0_ready,
  output logic              o_rsp0_valid,
  output logic [DATA_W-1:0] o_rsp0_rdata,
  input  logic              i_req1_valid,
  input  logic              i_req1_we,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_wdata,
  output logic              o_req1_ready,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp1_rdata,
  output logic [3:0]        o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  output logic              o_bus_we,
  output logic              o_bus_re,
  output logic [3:0]        o_pps_sel,
  output logic [3:0]        o_pulse_sel,
  output logic              o_mem_sel,
  output logic [6:0]        o_mem_addr,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  bus_state_e        state_q;
  logic              owner_q;
  logic              we_q;
  logic [2:0]        cnt_q;
  logic              bus_we_q;
  logic              bus_re_q;
  logic [3:0]        bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [3:0]        pps_sel_q;
  logic [3:0]        pulse_sel_q;
  logic              mem_sel_q;
  logic [6:0]        mem_addr_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp0_rdata_q;
  logic [DATA_W-1:0] rsp1_rdata_q;

  logic [1:0]        gnt_s;
  logic              accept_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  blk_sel_t          dec_s;

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    ({i_req1_valid, i_req0_valid}),
    .i_update (accept_s),
    .o_gnt    (gnt_s)
  );

  assign accept_s     = (state_q == ST_IDLE) && !i_rst && (gnt_s != 2'b00);
  assign o_req0_ready = accept_s && gnt_s[0];
  assign o_req1_ready = accept_s && gnt_s[1];
  assign dec_s        = blk_decode(sel_addr_s[ADDR_W-1 -: 4]);

  // Request fields of the granted host.
  always_comb begin
    if (gnt_s[1]) begin
      sel_we_s    = i_req1_we;
      sel_addr_s  = i_req1_addr;
      sel_wdata_s = i_req1_wdata;
    end else begin
      sel_we_s    = i_req0_we;
      sel_addr_s  = i_req0_addr;
      sel_wdata_s = i_req0_wdata;
    end
  end

  // Transaction FSM; bus and response outputs default to 0 and are only raised for one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= 3'd0;
      bus_we_q     <= 1'b0;
      bus_re_q     <= 1'b0;
      bus_addr_q   <= 4'd0;
      bus_wdata_q  <= '0;
      pps_sel_q    <= 4'd0;
      pulse_sel_q  <= 4'd0;
      mem_sel_q    <= 1'b0;
      mem_addr_q   <= 7'd0;
      rsp_valid_q  <= 2'b00;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      bus_we_q     <= 1'b0;
      bus_re_q     <= 1'b0;
      bus_addr_q   <= 4'd0;
      bus_wdata_q  <= '0;
      pps_sel_q    <= 4'd0;
      pulse_sel_q  <= 4'd0;
      mem_sel_q    <= 1'b0;
      mem_addr_q   <= 7'd0;
      rsp_valid_q  <= 2'b00;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            owner_q     <= gnt_s[1];
            we_q        <= sel_we_s;
            cnt_q       <= 3'(RD_LAT - 1);
            bus_we_q    <= sel_we_s;
            bus_re_q    <= !sel_we_s;
            bus_addr_q  <= sel_addr_s[3:0];
            bus_wdata_q <= sel_we_s ? sel_wdata_s : '0;
            pps_sel_q   <= dec_s.pps;
            pulse_sel_q <= dec_s.pulse;
            mem_sel_q   <= dec_s.mem;
            mem_addr_q  <= dec_s.mem ? sel_addr_s[6:0] : 7'd0;
            state_q     <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (we_q) begin
            rsp_valid_q[owner_q] <= 1'b1;
            state_q              <= ST_RESP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Counter reaches 0 in the cycle where the read data is valid on the bus.
          if (cnt_q == 3'd0) begin
            rsp_valid_q[owner_q] <= 1'b1;
            if (owner_q) begin
              rsp1_rdata_q <= i_bus_rdata;
            end else begin
              rsp0_rdata_q <= i_bus_rdata;
            end
            state_q <= ST_RESP;
          end else begin
            cnt_q   <= cnt_q - 3'd1;
            state_q <= ST_WAIT;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_bus_we     = bus_we_q;
  assign o_bus_re     = bus_re_q;
  assign o_bus_addr   = bus_addr_q;
  assign o_bus_wdata  = bus_wdata_q;
  assign o_pps_sel    = pps_sel_q;
  assign o_pulse_sel  = pulse_sel_q;
  assign o_mem_sel    = mem_sel_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_rsp0_valid = rsp_valid_q[0];
  assign o_rsp1_valid = rsp_valid_q[1];
  assign o_rsp0_rdata = rsp0_rdata_q;
  assign o_rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed, table-driven bench for reg_bus_arbiter (RD_LAT = 2).
module tb_reg_bus_arbiter;

  localparam int RD_LAT = 2;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_req0_valid, i_req0_we, i_req1_valid, i_req1_we;
  logic [7:0] i_req0_addr, i_req0_wdata, i_req1_addr, i_req1_wdata;
  logic       o_req0_ready, o_rsp0_valid, o_req1_ready, o_rsp1_valid;
  logic [7:0] o_rsp0_rdata, o_rsp1_rdata, o_bus_wdata, i_bus_rdata;
  logic [3:0] o_bus_addr, o_pps_sel, o_pulse_sel;
  logic       o_bus_we, o_bus_re, o_mem_sel;
  logic [6:0] o_mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       host;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;   // write data, or the value the bus model returns for a read
    logic [3:0] pps;
    logic [3:0] pulse;
    logic       mem;
    logic [6:0] maddr;
    logic [3:0] off;
  } vec_t;

  vec_t vecs[8];

  reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .i_req0_we(i_req0_we), .i_req0_addr(i_req0_addr),
    .i_req0_wdata(i_req0_wdata), .o_req0_ready(o_req0_ready), .o_rsp0_valid(o_rsp0_valid),
    .o_rsp0_rdata(o_rsp0_rdata),
    .i_req1_valid(i_req1_valid), .i_req1_we(i_req1_we), .i_req1_addr(i_req1_addr),
    .i_req1_wdata(i_req1_wdata), .o_req1_ready(o_req1_ready), .o_rsp1_valid(o_rsp1_valid),
    .o_rsp1_rdata(o_rsp1_rdata),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_we(o_bus_we), .o_bus_re(o_bus_re),
    .o_pps_sel(o_pps_sel), .o_pulse_sel(o_pulse_sel), .o_mem_sel(o_mem_sel),
    .o_mem_addr(o_mem_addr), .i_bus_rdata(i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #2;
  endtask

  task automatic drive_req(input logic host, input logic vld, input logic we,
                           input logic [7:0] addr, input logic [7:0] wd);
    if (host) begin
      i_req1_valid = vld; i_req1_we = we; i_req1_addr = addr; i_req1_wdata = wd;
    end else begin
      i_req0_valid = vld; i_req0_we = we; i_req0_addr = addr; i_req0_wdata = wd;
    end
  endtask

  // Bus must be fully quiet without a strobe; with a strobe exactly one strobe and one select.
  task automatic bus_monitor();
    forever begin
      @(negedge i_clk);
      if (!(o_bus_we || o_bus_re))
        chk("quiet bus", {o_pps_sel, o_pulse_sel, o_mem_sel, o_mem_addr, o_bus_addr, o_bus_wdata}, 32'd0);
      else
        chk("issue onehot", {31'd0, (o_bus_we ^ o_bus_re) && ($countones({o_pps_sel, o_pulse_sel, o_mem_sel}) == 1)}, 32'd1);
    end
  endtask

  // One transaction, starting in an IDLE cycle and ending in the next IDLE cycle.
  task automatic run_vec(input vec_t v, input string tag);
    int rsp_cyc;
    drive_req(v.host, 1'b1, v.we, v.addr, v.data);
    #1;
    chk({tag, " ready"}, v.host ? o_req1_ready : o_req0_ready, 32'd1);
    chk({tag, " other ready"}, v.host ? o_req0_ready : o_req1_ready, 32'd0);
    next_cycle();
    drive_req(v.host, 1'b0, 1'b0, 8'h00, 8'h00);
    chk({tag, " strobes"}, {o_bus_we, o_bus_re}, {v.we, !v.we});
    chk({tag, " selects"}, {o_pps_sel, o_pulse_sel, o_mem_sel}, {v.pps, v.pulse, v.mem});
    chk({tag, " offset"}, o_bus_addr, v.off);
    chk({tag, " mem addr"}, o_mem_addr, v.maddr);
    chk({tag, " wdata"}, o_bus_wdata, v.we ? v.data : 8'h00);
    rsp_cyc = v.we ? 2 : 2 + RD_LAT;
    for (int c = 2; c <= rsp_cyc; c++) begin
      next_cycle();
      i_bus_rdata = (!v.we && c == 1 + RD_LAT) ? v.data : 8'h00;
      if (c < rsp_cyc) begin
        chk({tag, " early rsp"}, {o_rsp0_valid, o_rsp1_valid}, 32'd0);
      end else begin
        chk({tag, " rsp valid"}, {o_rsp1_valid, o_rsp0_valid}, v.host ? 2'b10 : 2'b01);
        chk({tag, " rsp rdata"}, v.host ? o_rsp1_rdata : o_rsp0_rdata, v.we ? 8'h00 : v.data);
        chk({tag, " other rdata"}, v.host ? o_rsp0_rdata : o_rsp1_rdata, 32'd0);
      end
    end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g;
    logic [3:0] got_g;
    int         stamp[4];
    int         grants;
    vec_t       v;

    //           host  we    addr   data   pps      pulse    mem   maddr  off
    vecs[0] = '{1'b0, 1'b1, 8'h21, 8'h5A, 4'b0100, 4'b0000, 1'b0, 7'h00, 4'h1};
    vecs[1] = '{1'b1, 1'b0, 8'h93, 8'hC3, 4'b0000, 4'b0000, 1'b1, 7'h13, 4'h3};
    vecs[2] = '{1'b0, 1'b0, 8'h7F, 8'h3C, 4'b0000, 4'b1000, 1'b0, 7'h00, 4'hF};
    vecs[3] = '{1'b1, 1'b1, 8'h05, 8'hA5, 4'b0001, 4'b0000, 1'b0, 7'h00, 4'h5};
    vecs[4] = '{1'b0, 1'b0, 8'h42, 8'h81, 4'b0000, 4'b0001, 1'b0, 7'h00, 4'h2};
    vecs[5] = '{1'b1, 1'b1, 8'hF0, 8'h11, 4'b0000, 4'b0000, 1'b1, 7'h70, 4'h0};
    vecs[6] = '{1'b0, 1'b0, 8'h3E, 8'hFF, 4'b1000, 4'b0000, 1'b0, 7'h00, 4'hE};
    vecs[7] = '{1'b1, 1'b0, 8'h8C, 8'h7E, 4'b0000, 4'b0000, 1'b1, 7'h0C, 4'hC};

    i_rst = 1'b1;
    i_bus_rdata = 8'h00;
    drive_req(1'b0, 1'b1, 1'b1, 8'h21, 8'h5A);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    fork bus_monitor(); join_none

    // Reset: outputs 0 even with a request pending.
    for (int i = 0; i < 3; i++) next_cycle();
    #1;
    chk("reset bus outs", {o_bus_we, o_bus_re, o_pps_sel, o_pulse_sel, o_mem_sel, o_mem_addr, o_bus_addr}, 32'd0);
    chk("reset host outs", {o_bus_wdata, o_rsp0_valid, o_rsp1_valid, o_rsp0_rdata, o_rsp1_rdata,
                            o_req0_ready, o_req1_ready}, 32'd0);
    i_rst = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    next_cycle();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both hosts hold valid across four writes; last served was host1.
`ifdef REG_BUS_ARB_FIXED_PRIO_EN
    exp_g = 4'b0000;
`else
    exp_g = 4'b1010;
`endif
    got_g  = 4'b0000;
    grants = 0;
    drive_req(1'b0, 1'b1, 1'b1, 8'h10, 8'h01);
    drive_req(1'b1, 1'b1, 1'b1, 8'h50, 8'h02);
    for (int c = 0; c < 40 && grants < 4; c++) begin
      #1;
      if (o_req0_ready || o_req1_ready) begin
        chk("single ready", {o_req0_ready, o_req1_ready} == 2'b11, 32'd0);
        got_g[grants]  = o_req1_ready;
        stamp[grants]  = c;
        grants++;
      end
      next_cycle();
    end
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("grant count", grants, 32'd4);
    chk("grant order", got_g, exp_g);
    for (int i = 1; i < 4; i++) chk("write spacing", stamp[i] - stamp[i-1], 32'd3);
    next_cycle();
    chk("rr last rsp", {o_rsp1_valid, o_rsp0_valid}, exp_g[3] ? 2'b10 : 2'b01);
    next_cycle();

    // Reset during WAIT of a host0 read drops it; a host1 request pending in ISSUE is not taken.
    drive_req(1'b0, 1'b1, 1'b0, 8'h22, 8'h00);
    next_cycle();
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b1, 1'b0, 8'h93, 8'h00);
    #1;
    chk("busy ready1", o_req1_ready, 32'd0);
    next_cycle();
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    i_rst = 1'b1;
    next_cycle();
    i_rst = 1'b0;
    chk("post-rst bus outs", {o_bus_we, o_bus_re, o_pps_sel, o_pulse_sel, o_mem_sel, o_mem_addr, o_bus_addr}, 32'd0);
    chk("post-rst host outs", {o_bus_wdata, o_rsp0_valid, o_rsp1_valid, o_rsp0_rdata, o_rsp1_rdata,
                               o_req0_ready, o_req1_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("no rsp after rst", {o_rsp0_valid, o_rsp1_valid}, 32'd0);
    end
    v = vecs[1];
    run_vec(v, "after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
